// File: rtl/instr_sequencer.sv
// Instruction sequencer for the tiny core: fetch, decode, optional data access,
// PC step and settle, with a bounded memory wait that traps to a terminal error.
module instr_sequencer #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_current,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              is_halt,
  input  logic              mem_ready,
  input  logic              resume,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              ir_we,
  output logic              rf_we,
  output logic              pc_step,
  output logic              halted,
  output logic              timeout_err
);

  localparam int unsigned WAIT_W   = 4;
  localparam int unsigned SETTLE_W = 2;
  localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(1);

  typedef enum logic [2:0] {
    S_START,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_WB,
    S_SETTLE,
    S_HALT,
    S_ERROR
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                op_store;
  logic                op_load;
  logic [ADDR_W-1:0]   addr_q;
  logic                mem_phase;

  assign mem_phase = (state == S_FETCH) || (state == S_MEM);

  // State, wait/settle counters and the decoded operation latched in DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_START;
      wait_cnt   <= '0;
      settle_cnt <= '0;
      op_store   <= 1'b0;
      op_load    <= 1'b0;
      addr_q     <= '0;
    end else begin
      state <= state_next;
      // Counter is zero on every entry to FETCH/MEM since no request state
      // follows another without a mem_ready cycle in between.
      wait_cnt   <= (mem_phase && !mem_ready) ? wait_cnt + WAIT_W'(1) : '0;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + SETTLE_W'(1) : '0;
      if (state == S_DECODE) begin
        op_store <= is_store && !is_halt;
        op_load  <= is_load && !is_store && !is_halt;
        addr_q   <= data_addr;
      end else if (state == S_HALT && resume) begin
        op_store <= 1'b0;
        op_load  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    pc_step     = 1'b0;
    halted      = 1'b0;
    timeout_err = 1'b0;
    case (state)
      S_START: state_next = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_current;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = S_ERROR;
        end
      end
      S_DECODE: begin
        if (is_halt)                  state_next = S_HALT;
        else if (is_load || is_store) state_next = S_MEM;
        else                          state_next = S_WB;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = op_store;
        mem_addr = addr_q;
        if (mem_ready)                    state_next = S_WB;
        else if (wait_cnt == WAIT_LAST)   state_next = S_ERROR;
      end
      S_WB: begin
        pc_step    = 1'b1;
        rf_we      = op_load || !op_store;  // loads and ALU ops write back
        state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) begin
          pc_step    = 1'b1;
          state_next = S_SETTLE;
        end
      end
      S_ERROR: begin
        halted      = 1'b1;
        timeout_err = 1'b1;
      end
      default: state_next = S_START;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; outputs are sampled 2 time
// units after the rising edge, once new inputs for that cycle have been applied.
module tb_instr_sequencer;
  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc_current;
  logic [ADDR_W-1:0] data_addr;
  logic              is_load, is_store, is_halt, mem_ready, resume;
  logic              mem_req, mem_we, ir_we, rf_we, pc_step, halted, timeout_err;
  logic [ADDR_W-1:0] mem_addr;

  int compared   = 0;
  int mismatched = 0;

  // Packed observation order: req, we, ir_we, rf_we, pc_step, halted, timeout_err
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_REQ   = 7'b1000000;
  localparam logic [6:0] O_WR    = 7'b1100000;
  localparam logic [6:0] O_FETCH = 7'b1010000;
  localparam logic [6:0] O_WB    = 7'b0001100;
  localparam logic [6:0] O_WBST  = 7'b0000100;
  localparam logic [6:0] O_HALT  = 7'b0000010;
  localparam logic [6:0] O_RESUM = 7'b0000110;
  localparam logic [6:0] O_ERR   = 7'b0000011;

  always #5 clk = ~clk;

  instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .pc_current(pc_current), .data_addr(data_addr),
    .is_load(is_load), .is_store(is_store), .is_halt(is_halt),
    .mem_ready(mem_ready), .resume(resume), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .ir_we(ir_we), .rf_we(rf_we), .pc_step(pc_step),
    .halted(halted), .timeout_err(timeout_err)
  );

  function automatic logic [6:0] outs();
    return {mem_req, mem_we, ir_we, rf_we, pc_step, halted, timeout_err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in START for the current cycle with all inputs idle.
  task automatic do_reset();
    rst = 1'b1; is_load = 0; is_store = 0; is_halt = 0; mem_ready = 0; resume = 0;
    data_addr = '0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pc_current = 10'h155;
    do_reset();
    #1;
    compared++;
    if (outs() !== O_IDLE || mem_addr !== '0) begin
      mismatched++;
      $display("FAIL reset_outs: got %b/%h expected %b/000", outs(), mem_addr, O_IDLE);
    end
    cyc();
    #1;
    compared++;
    if (outs() !== O_REQ || mem_addr !== pc_current) begin
      mismatched++;
      $display("FAIL reset_first_fetch: got %b/%h expected %b/%h", outs(), mem_addr, O_REQ, pc_current);
    end
  endtask

  task automatic test_alu_loop();
    logic [6:0]        exp_o;
    logic [ADDR_W-1:0] exp_a;
    do_reset();
    pc_current = 10'h100;
    mem_ready  = 1'b1;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (i % 5 == 3) pc_current = pc_current + 10'd1;
      #1;
      exp_o = (i % 5 == 0) ? O_FETCH : (i % 5 == 2) ? O_WB : O_IDLE;
      exp_a = (i % 5 == 0) ? pc_current : '0;
      compared++;
      if (outs() !== exp_o || mem_addr !== exp_a) begin
        mismatched++;
        $display("FAIL alu_loop cyc%0d: got %b/%h expected %b/%h", i, outs(), mem_addr, exp_o, exp_a);
      end
    end
  endtask

  task automatic test_load_wait();
    do_reset();
    pc_current = 10'h040; is_load = 1'b1; data_addr = 10'h2A5; mem_ready = 1'b1;
    cyc(); #1;
    compared++;
    if (outs() !== O_FETCH || mem_addr !== 10'h040) begin
      mismatched++;
      $display("FAIL load_fetch: got %b/%h expected %b/040", outs(), mem_addr, O_FETCH);
    end
    cyc(); mem_ready = 1'b0; #1;
    compared++;
    if (outs() !== O_IDLE) begin
      mismatched++;
      $display("FAIL load_decode: got %b expected %b", outs(), O_IDLE);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(); mem_ready = (i == 4); #1;
      compared++;
      if (outs() !== O_REQ || mem_addr !== 10'h2A5) begin
        mismatched++;
        $display("FAIL load_mem cyc%0d: got %b/%h expected %b/2a5", i, outs(), mem_addr, O_REQ);
      end
    end
    cyc(); is_load = 1'b0; #1;
    compared++;
    if (outs() !== O_WB) begin
      mismatched++;
      $display("FAIL load_wb: got %b expected %b", outs(), O_WB);
    end
  endtask

  task automatic test_store();
    int n_we = 0;
    do_reset();
    pc_current = 10'h080; is_store = 1'b1; data_addr = 10'h013; mem_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cyc(); #1;
      if (c <= 6) n_we += int'(mem_we);
      if (c == 3) begin
        compared++;
        if (outs() !== O_WR || mem_addr !== 10'h013) begin
          mismatched++;
          $display("FAIL store_mem: got %b/%h expected %b/013", outs(), mem_addr, O_WR);
        end
      end
      if (c == 4) begin
        compared++;
        if (outs() !== O_WBST) begin
          mismatched++;
          $display("FAIL store_wb: got %b expected %b", outs(), O_WBST);
        end
      end
      if (c == 7) begin
        compared++;
        if (outs() !== O_FETCH) begin
          mismatched++;
          $display("FAIL store_next_fetch: got %b expected %b", outs(), O_FETCH);
        end
      end
    end
    is_store = 1'b0;
    compared++;
    if (n_we !== 1) begin
      mismatched++;
      $display("FAIL store_we_cycles: got %0d expected 1", n_we);
    end
  endtask

  task automatic test_timeout();
    int n_err = 0;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      cyc(); #1;
      compared++;
      if (outs() !== O_REQ) begin
        mismatched++;
        $display("FAIL timeout_wait cyc%0d: got %b expected %b", k, outs(), O_REQ);
      end
    end
    cyc(); #1;
    compared++;
    if (outs() !== O_ERR) begin
      mismatched++;
      $display("FAIL timeout_enter: got %b expected %b", outs(), O_ERR);
    end
    for (int k = 0; k < 50; k++) begin
      cyc(); mem_ready = 1'($urandom); resume = 1'b1; #1;
      if (outs() === O_ERR) n_err++;
    end
    compared++;
    if (n_err !== 50) begin
      mismatched++;
      $display("FAIL timeout_sticky: got %0d error cycles expected 50", n_err);
    end
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      cyc(); mem_ready = (k == 15); #1;
    end
    compared++;
    if (outs() !== O_FETCH) begin
      mismatched++;
      $display("FAIL timeout_last_ready: got %b expected %b", outs(), O_FETCH);
    end
    cyc(); mem_ready = 1'b0; #1;
    compared++;
    if (outs() !== O_IDLE) begin
      mismatched++;
      $display("FAIL timeout_decode: got %b expected %b", outs(), O_IDLE);
    end
    cyc(); #1;
    compared++;
    if (outs() !== O_WB) begin
      mismatched++;
      $display("FAIL timeout_wb: got %b expected %b", outs(), O_WB);
    end
  endtask

  task automatic test_halt();
    int n_halt = 0;
    do_reset();
    mem_ready = 1'b1; is_halt = 1'b1;
    cyc(); cyc(); cyc(); is_halt = 1'b0; #1;
    compared++;
    if (outs() !== O_HALT) begin
      mismatched++;
      $display("FAIL halt_enter: got %b expected %b", outs(), O_HALT);
    end
    for (int k = 0; k < 20; k++) begin
      cyc(); #1;
      if (outs() === O_HALT) n_halt++;
    end
    compared++;
    if (n_halt !== 20) begin
      mismatched++;
      $display("FAIL halt_hold: got %0d halted cycles expected 20", n_halt);
    end
    resume = 1'b1; #1;
    compared++;
    if (outs() !== O_RESUM) begin
      mismatched++;
      $display("FAIL halt_resume: got %b expected %b", outs(), O_RESUM);
    end
    cyc(); resume = 1'b0; #1;
    compared++;
    if (outs() !== O_IDLE) begin
      mismatched++;
      $display("FAIL halt_settle1: got %b expected %b", outs(), O_IDLE);
    end
    cyc(); #1;
    compared++;
    if (outs() !== O_IDLE) begin
      mismatched++;
      $display("FAIL halt_settle2: got %b expected %b", outs(), O_IDLE);
    end
    // Now in FETCH: halt with store also set must win, and resume held high
    // on entry leaves after exactly one HALT cycle.
    cyc(); is_halt = 1'b1; is_store = 1'b1; resume = 1'b1; #1;
    compared++;
    if (outs() !== O_FETCH) begin
      mismatched++;
      $display("FAIL halt_refetch: got %b expected %b", outs(), O_FETCH);
    end
    cyc(); cyc(); #1;
    compared++;
    if (outs() !== O_RESUM) begin
      mismatched++;
      $display("FAIL halt_prio_resume: got %b expected %b", outs(), O_RESUM);
    end
    cyc(); is_halt = 1'b0; is_store = 1'b0; resume = 1'b0; #1;
    compared++;
    if (outs() !== O_IDLE) begin
      mismatched++;
      $display("FAIL halt_prio_leave: got %b expected %b", outs(), O_IDLE);
    end
  endtask

  task automatic test_reset_mid_store();
    do_reset();
    pc_current = 10'h0C3; is_store = 1'b1; data_addr = 10'h013; mem_ready = 1'b1;
    cyc(); cyc(); mem_ready = 1'b0;
    cyc(); cyc(); #1;
    compared++;
    if (outs() !== O_WR || mem_addr !== 10'h013) begin
      mismatched++;
      $display("FAIL rstmid_before: got %b/%h expected %b/013", outs(), mem_addr, O_WR);
    end
    rst = 1'b1;
    cyc(); is_store = 1'b0; #1;
    compared++;
    if (outs() !== O_IDLE || mem_addr !== '0) begin
      mismatched++;
      $display("FAIL rstmid_start: got %b/%h expected %b/000", outs(), mem_addr, O_IDLE);
    end
    rst = 1'b0;
    cyc(); #1;
    compared++;
    if (outs() !== O_REQ || mem_addr !== 10'h0C3) begin
      mismatched++;
      $display("FAIL rstmid_fetch: got %b/%h expected %b/0c3", outs(), mem_addr, O_REQ);
    end
    for (int k = 2; k <= 15; k++) begin
      cyc(); mem_ready = (k == 15); #1;
    end
    compared++;
    if (outs() !== O_FETCH) begin
      mismatched++;
      $display("FAIL rstmid_wait_restart: got %b expected %b", outs(), O_FETCH);
    end
    cyc(); mem_ready = 1'b0; #1;
    compared++;
    if (outs() !== O_IDLE) begin
      mismatched++;
      $display("FAIL rstmid_decode: got %b expected %b", outs(), O_IDLE);
    end
  endtask

  initial begin
    rst = 1'b1; pc_current = '0; data_addr = '0;
    is_load = 0; is_store = 0; is_halt = 0; mem_ready = 0; resume = 0;
    test_reset();
    test_alu_loop();
    test_load_wait();
    test_store();
    test_timeout();
    test_halt();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
